reg_bank_bus_seq: RTL

Parametrised register bank with a bus sequencer: 2^SELW registers of WIDTH bits, loaded from a data input, driven onto a shared tri-state bus, and manipulated by multi-cycle operations (move, swap, increment, decrement, clear) under a START/BUSY/DONE handshake. It is the sequential successor of the fixed 4×16-bit register-to-bus selector. The control unit issues one operation at a time and owns the bus whenever BUSY is low or BUS_Z is high-Z.

---
 rtl/reg_bank_bus_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/reg_bank_bus_seq.sv
// Register bank of 2^SELW x WIDTH registers with a multi-cycle operation sequencer.
// One operation runs at a time under a START/BUSY/DONE handshake, and the bank can drive a shared tri-state bus.
module reg_bank_bus_seq #(
  parameter int WIDTH = 16,
  parameter int SELW  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [SELW-1:0]  SEL_A,
  input  logic [SELW-1:0]  SEL_B,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] BUS_Z,
  output logic [WIDTH-1:0] RD_Q,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       dbg_state,
  output logic             bus_drive
);
  // Handshake: START is accepted only on an edge where BUSY is low. The operation,
  // indices and data are captured on that edge. DONE pulses for one cycle just before
  // BUSY falls. A START seen while BUSY is high is dropped; it is not queued.
  localparam int NREGS = 2 ** SELW;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_MOVE  = 3'b011;
  localparam logic [2:0] OP_INC   = 3'b100;
  localparam logic [2:0] OP_DEC   = 3'b101;
  localparam logic [2:0] OP_CLR   = 3'b110;
  localparam logic [2:0] OP_SWAP  = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WB1, S_WB2, S_DONE} state_t;

  state_t            state, next_state;
  logic [WIDTH-1:0]  regs [NREGS];
  logic [2:0]        op_q;
  logic [SELW-1:0]   a_q, b_q;
  logic [WIDTH-1:0]  d_q, t_q;
  logic              wr_en, t_ld;
  logic [SELW-1:0]   wr_idx;
  logic [WIDTH-1:0]  wr_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      op_q  <= OP_NOP;
      a_q   <= '0;
      b_q   <= '0;
      d_q   <= '0;
      t_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && START) begin
        op_q <= OP;
        a_q  <= SEL_A;
        b_q  <= SEL_B;
        d_q  <= DIN;
      end
      if (t_ld) t_q <= regs[a_q];
      if (wr_en) regs[wr_idx] <= wr_data;
    end
  end

  // At most one bank write per cycle; SWAP spreads its two writes over WB1 and WB2.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    wr_idx     = a_q;
    wr_data    = d_q;
    t_ld       = 1'b0;
    case (state)
      S_IDLE: if (START) next_state = S_EXEC;
      S_EXEC: begin
        next_state = (op_q == OP_MOVE || op_q == OP_SWAP) ? S_WB1 : S_DONE;
        case (op_q)
          OP_LOAD: wr_en = 1'b1;
          OP_INC: begin
            wr_en   = 1'b1;
            wr_data = regs[a_q] + ONE;
          end
          OP_DEC: begin
            wr_en   = 1'b1;
            wr_data = regs[a_q] - ONE;
          end
          OP_CLR: begin
            wr_en   = 1'b1;
            wr_data = '0;
          end
          OP_MOVE, OP_SWAP: t_ld = 1'b1;
          default: ;
        endcase
      end
      S_WB1: begin
        next_state = (op_q == OP_SWAP) ? S_WB2 : S_DONE;
        wr_en      = 1'b1;
        if (op_q == OP_SWAP) begin
          wr_idx  = a_q;
          wr_data = regs[b_q];
        end else begin
          wr_idx  = b_q;
          wr_data = t_q;
        end
      end
      S_WB2: begin
        next_state = S_DONE;
        wr_en      = 1'b1;
        wr_idx     = b_q;
        wr_data    = t_q;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_DONE);
  assign dbg_state = state;
  // The bus is driven only during the single EXEC cycle of STORE or MOVE.
  assign bus_drive = (state == S_EXEC) && (op_q == OP_STORE || op_q == OP_MOVE);
  assign BUS_Z     = bus_drive ? regs[a_q] : {WIDTH{1'bz}};
  assign RD_Q      = regs[SEL_A];
endmodule
